// File: rtl/adder_pkg.sv
// Shared constants and types for the 16-bit registered adder.
package adder_pkg;

  localparam int unsigned ADD_WIDTH = 16;
  localparam int unsigned CLA_SLICE = 4;

  typedef logic [ADD_WIDTH-1:0] word_t;

  // Full-width reference add: returns {carry_out, sum}.
  function automatic logic [ADD_WIDTH:0] ref_add(word_t x, word_t y, logic c);
    return {1'b0, x} + {1'b0, y} + {{ADD_WIDTH{1'b0}}, c};
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla4_slice
  import adder_pkg::*;
(
  input  logic [CLA_SLICE-1:0] a,
  input  logic [CLA_SLICE-1:0] b,
  input  logic                 cin,
  output logic [CLA_SLICE-1:0] sum,
  output logic                 cout,
  output logic                 gg,
  output logic                 pp
);

  logic [CLA_SLICE-1:0] g;
  logic [CLA_SLICE-1:0] p;
  logic [CLA_SLICE-1:0] c;

  // Per-bit generate/propagate and fully expanded lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    cout = gg | (pp & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/sixteen_bit_adder.sv
// 16-bit adder: four CLA slices rippling carry, result registered.
module sixteen_bit_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int unsigned NumSlices = WIDTH / SLICE;

  logic [NumSlices:0]   carry;
  logic [WIDTH-1:0]     sum_n;
  logic [NumSlices-1:0] grp_g;
  logic [NumSlices-1:0] grp_p;
  logic [WIDTH-1:0]     s_q;
  logic                 co_q;

  assign carry[0] = Ci;

  for (genvar k = 0; k < NumSlices; k++) begin : g_slice
    cla4_slice u_slice (
      .a    (a[k*SLICE +: SLICE]),
      .b    (b[k*SLICE +: SLICE]),
      .cin  (carry[k]),
      .sum  (sum_n[k*SLICE +: SLICE]),
      .cout (carry[k+1]),
      .gg   (grp_g[k]),
      .pp   (grp_p[k])
    );
  end

  // Group G/P are reserved for a future second lookahead level.
  logic unused_grp;
  assign unused_grp = ^{grp_g, grp_p};

  // Output register; async reset clears the held result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= sum_n;
      co_q <= carry[NumSlices];
    end
  end

  assign S  = s_q;
  assign Co = co_q;

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Directed and random checks for sixteen_bit_adder.
module tb_sixteen_bit_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        Ci;
  logic [15:0] S;
  logic        Co;

  int total = 0;
  int bad   = 0;

  sixteen_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .Ci    (Ci),
    .S     (S),
    .Co    (Co)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] es, input logic ec);
    total++;
    assert (S === es && Co === ec)
    else begin
      bad++;
      $error("FAIL %s: got S=%h Co=%b, want S=%h Co=%b", tag, S, Co, es, ec);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] r;

    // Reset is asserted with non-zero inputs and before any clock edge.
    rst_n = 1'b0;
    a = 16'h1234; b = 16'h1111; Ci = 1'b1;
    #2;
    chk("reset_async", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_after_reset", 16'h2346, 1'b0);

    a = 16'd10; b = 16'd6; Ci = 1'b0;
    step();
    chk("basic_ci0", 16'h0010, 1'b0);
    Ci = 1'b1;
    step();
    chk("basic_ci1", 16'h0011, 1'b0);

    a = 16'd200; b = 16'd100; Ci = 1'b0;
    #2;
    chk("hold_before_edge", 16'h0011, 1'b0);
    step();
    chk("midrange", 16'h012C, 1'b0);

    a = 16'hFFFF; b = 16'h0001; Ci = 1'b0;
    step();
    chk("wrap", 16'h0000, 1'b1);
    a = 16'hFFFF; b = 16'hFFFF; Ci = 1'b1;
    step();
    chk("max_all", 16'hFFFF, 1'b1);

    a = 16'h0000; b = 16'h0000; Ci = 1'b1;
    step();
    chk("zero_ci", 16'h0001, 1'b0);

    a = 16'h0FFF; b = 16'h0000; Ci = 1'b1;
    step();
    chk("ripple3", 16'h1000, 1'b0);
    a = 16'h00F0; b = 16'h0010; Ci = 1'b0;
    step();
    chk("ripple1", 16'h0100, 1'b0);

    // Random back-to-back vectors with a mid-run reset pulse.
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      Ci = 1'($urandom_range(0, 1));
      r  = {1'b0, a} + {1'b0, b} + {16'h0000, Ci};
      step();
      chk("random", r[15:0], r[16]);
      if (i == 500) begin
        rst_n = 1'b0;
        #2;
        chk("reset_midrun", 16'h0000, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("reset_released_hold", 16'h0000, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_adder.md
Name: sixteen_bit_adder

Overview:
- 16-bit binary adder with carry-in and carry-out; outputs are registered.
- Generic arithmetic leaf for datapaths that need a 16-bit add with carry chaining, e.g. cascading two instances for a 32-bit add.
- Internally built as four 4-bit carry-lookahead slices with ripple carry between slices, followed by an output register stage.

Parameters:
- WIDTH, 16, operand and sum width; fixed at 16, so other values are unsupported.
- SLICE, 4, bits per carry-lookahead slice; WIDTH must be a multiple of SLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  16  operand A, unsigned.
- b  input  16  operand B, unsigned.
- Ci  input  1  carry-in.
- S  output  16  registered sum, (a + b + Ci) mod 2^16.
- Co  output  1  registered carry-out, bit 16 of a + b + Ci.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n = 0: S = 16'h0000 and Co = 0, immediately and independent of clk.
  - After rst_n deasserts, the first rising clk edge loads a valid result.
- Arithmetic:
  - Combinational result {Co_n, S_n} = a + b + Ci, computed at 17-bit width with no truncation before the register.
  - Operands are unsigned; no overflow flag is produced.
  - Signed overflow is not reported. A consumer that needs it derives it externally.
- Latency and throughput:
  - Latency is exactly 1 cycle. Inputs sampled at rising edge N appear on S/Co after edge N.
  - Throughput is one add per cycle; there is no handshake and no valid signal.
  - Outputs hold between edges; inputs are not registered separately.
- Slice structure:
  - Each slice computes per-bit generate g = a&b and propagate p = a^b.
  - Slice group carries: c[i+1] = g[i] | p[i]&c[i], expanded to two-level lookahead inside the slice.
  - Slice sum bit: s = p ^ c.
  - Slice 0 carry-in is Ci. The carry-out of slice k feeds slice k+1. The carry-out of slice 3 is Co_n.
- Boundary conditions:
  - 16'hFFFF + 16'h0001 + 0: S = 16'h0000, Co = 1 (wrap-around).
  - 16'hFFFF + 16'hFFFF + 1: S = 16'hFFFF, Co = 1.
  - 0 + 0 + 1: S = 16'h0001, Co = 0.
  - Reset asserted mid-stream clears S/Co at once; the held result is discarded. After release, the next edge captures the current inputs.
- Timing target: the critical path is bounded by four slice carry-lookahead levels plus ripple. No multicycle paths.

Decomposition:
- Shared package (adder_pkg):
  - constants ADD_WIDTH = 16 and CLA_SLICE = 4.
  - typedef word_t = logic [15:0].
- One sub-module: cla4_slice.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout, plus group generate/propagate outputs for future two-level lookahead.
  - sixteen_bit_adder instantiates four cla4_slice in a generate loop, then registers {cout3, sum}.

Test Plan:
- Reset: assert rst_n = 0 with a = 16'h1234, b = 16'h1111, Ci = 1 -> S = 16'h0000 and Co = 0 without any clock edge. Release, one edge -> S = 16'h2346, Co = 0.
- Basic add: a = 10, b = 6, Ci = 0 -> after 1 edge, S = 16'h0010, Co = 0. Same operands with Ci = 1 -> S = 16'h0011, Co = 0.
- Mid-range: a = 200, b = 100, Ci = 0 -> S = 16'h012C, Co = 0. Check that S is unchanged before the edge and updated after it.
- Wrap and overflow: a = 16'hFFFF, b = 16'h0001, Ci = 0 -> S = 16'h0000, Co = 1. Then a = b = 16'hFFFF, Ci = 1 -> S = 16'hFFFF, Co = 1.
- Slice carry chain: a = 16'h0FFF, b = 16'h0000, Ci = 1 -> S = 16'h1000, Co = 0 (carry ripples through three slices). Then a = 16'h00F0, b = 16'h0010, Ci = 0 -> S = 16'h0100.
- Back-to-back and random: change operands every cycle for 1000 random vectors including Ci. Each output must equal the 17-bit reference sum of the previous cycle's inputs. Assert rst_n mid-run -> outputs clear asynchronously, and the next post-release edge gives the correct sum.
